// File: rtl/approx_mul_err_monitor.sv
// Streaming error-metrics collector for the 16x16 approximate Booth multipliers.
// Optional feature: define ERRMON_SIGNED_SUM_EN to build the signed ED accumulator (sum_err).
module approx_mul_err_monitor #(
  parameter int W     = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic [2*W-1:0]   p_approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [2*W:0]     max_abs_err,
  output logic [ACC_W-1:0] sum_err
);

  localparam int ED_W  = 2*W + 1;
  // One guard bit above the wider of accumulator and |ED| so the saturation test never wraps.
  localparam int SUM_W = ((ACC_W > ED_W) ? ACC_W : ED_W) + 1;
  localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'({ACC_W{1'b1}});

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fire;

  logic                   s1_valid_q, s2_valid_q;
  logic signed [W-1:0]    s1_x_q, s1_y_q;
  logic [2*W-1:0]         s1_p_q;
  logic signed [2*W-1:0]  prod_exact;
  logic signed [ED_W-1:0] ed_d, ed_q;
  logic [ED_W-1:0]        abs_d, abs_q;
  logic [SUM_W-1:0]       sum_abs_wide;

  logic [CNT_W-1:0] sample_cnt_q, err_cnt_q;
  logic [ACC_W-1:0] sum_abs_q;
  logic [ED_W-1:0]  max_abs_q;

  // start wins over any coincident transfer.
  assign fire = in_valid && in_ready_q && !start;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    num_d     = num_q;
    if (start) begin
      state_d   = ST_RUN;
      acc_cnt_d = '0;
      num_d     = num_samples;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          acc_cnt_d = acc_cnt_q + CNT_W'(fire);
          if (acc_cnt_d == num_q) state_d = ST_DRAIN;
        end
        ST_DRAIN: if (!s1_valid_q && !s2_valid_q) state_d = ST_DONE;
        default: ;
      endcase
    end
    in_ready_d = (state_d == ST_RUN) && (acc_cnt_d != num_d);
    busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d     = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_cnt_q  <= '0;
      num_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_cnt_q  <= acc_cnt_d;
      num_q      <= num_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign prod_exact   = (2*W)'(s1_x_q) * (2*W)'(s1_y_q);
  assign ed_d         = $signed({s1_p_q[2*W-1], s1_p_q}) - $signed({prod_exact[2*W-1], prod_exact});
  assign abs_d        = ed_d[ED_W-1] ? -ed_d : ed_d;
  assign sum_abs_wide = SUM_W'(sum_abs_q) + SUM_W'(abs_q);

  // NOTE: pipeline data registers are reset too, so every output reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s1_p_q       <= '0;
      ed_q         <= '0;
      abs_q        <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      sum_abs_q    <= '0;
      max_abs_q    <= '0;
    end else begin
      s1_valid_q <= fire;
      s2_valid_q <= s1_valid_q && !start;
      if (fire) begin
        s1_x_q <= x;
        s1_y_q <= y;
        s1_p_q <= p_approx;
      end
      if (s1_valid_q) begin
        ed_q  <= ed_d;
        abs_q <= abs_d;
      end
      if (start) begin
        sample_cnt_q <= '0;
        err_cnt_q    <= '0;
        sum_abs_q    <= '0;
        max_abs_q    <= '0;
      end else if (s2_valid_q) begin
        sample_cnt_q <= sample_cnt_q + 1'b1;
        if (ed_q != '0) err_cnt_q <= err_cnt_q + 1'b1;
        sum_abs_q <= (sum_abs_wide > SAT_MAX) ? {ACC_W{1'b1}} : sum_abs_wide[ACC_W-1:0];
        if (abs_q > max_abs_q) max_abs_q <= abs_q;
      end
    end
  end

`ifdef ERRMON_SIGNED_SUM_EN
  logic [ACC_W-1:0] sum_err_q;

  // Two's-complement wrap is intended; ED is sign-extended or truncated to ACC_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          sum_err_q <= '0;
    else if (start)      sum_err_q <= '0;
    else if (s2_valid_q) sum_err_q <= sum_err_q + ACC_W'(ed_q);
  end

  assign sum_err = sum_err_q;
`else
  assign sum_err = '0;
`endif

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sample_cnt  = sample_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign sum_abs_err = sum_abs_q;
  assign max_abs_err = max_abs_q;

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Scoreboard bench for approx_mul_err_monitor: per-sample expected stats from a reference model.
`timescale 1ns/1ps
module tb_approx_mul_err_monitor;

  localparam int W = 16, CNT_W = 32, ACC_W = 48, SAT_W = 8;
  localparam longint SAT_MAX = (longint'(1) << ACC_W) - 1;
`ifdef ERRMON_SIGNED_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] err;
    logic [ACC_W-1:0] sabs;
    logic [2*W:0]     mx;
    logic [ACC_W-1:0] sum;
    int               due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0, n_cmp = 0, n_bad = 0;
  longint m_cnt, m_err, m_sabs, m_max;
  logic [ACC_W-1:0] m_sum;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;
  logic signed [W-1:0] x = '0, y = '0;
  logic signed [2*W-1:0] p_approx = '0;
  logic in_ready, busy, done;
  logic [CNT_W-1:0] sample_cnt, err_cnt;
  logic [ACC_W-1:0] sum_abs_err, sum_err;
  logic [2*W:0] max_abs_err;

  logic s_start = 1'b0, s_valid = 1'b0;
  logic [CNT_W-1:0] s_num = '0;
  logic signed [W-1:0] s_x = '0, s_y = '0;
  logic signed [2*W-1:0] s_p = '0;
  logic s_ready, s_busy, s_done;
  logic [CNT_W-1:0] s_cnt, s_err;
  logic [SAT_W-1:0] s_sabs, s_sum;
  logic [2*W:0] s_max;

  approx_mul_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .p_approx(p_approx),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err), .sum_err(sum_err)
  );

  approx_mul_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .num_samples(s_num),
    .in_valid(s_valid), .in_ready(s_ready), .x(s_x), .y(s_y), .p_approx(s_p),
    .busy(s_busy), .done(s_done), .sample_cnt(s_cnt), .err_cnt(s_err),
    .sum_abs_err(s_sabs), .max_abs_err(s_max), .sum_err(s_sum)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit (got no finish, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    m_cnt = 0; m_err = 0; m_sabs = 0; m_max = 0; m_sum = '0;
  endtask

  task automatic push_model(input logic signed [W-1:0] xi, input logic signed [W-1:0] yi,
                            input logic signed [2*W-1:0] pi);
    longint ed, ae;
    exp_t e;
    ed = longint'(pi) - longint'(xi) * longint'(yi);
    ae = (ed < 0) ? -ed : ed;
    m_cnt++;
    if (ed != 0) m_err++;
    m_sabs = (m_sabs + ae > SAT_MAX) ? SAT_MAX : m_sabs + ae;
    if (ae > m_max) m_max = ae;
    m_sum = m_sum + ACC_W'(ed);
    e.cnt = CNT_W'(m_cnt); e.err = CNT_W'(m_err); e.sabs = ACC_W'(m_sabs);
    e.mx = (2*W+1)'(m_max); e.sum = SUM_EN ? m_sum : '0; e.due = cyc + 2;
    sb.push_back(e);
  endtask

  // Advances one clock; a transfer seen before the edge queues its expected stats.
  task automatic step();
    bit f;
    f = in_valid && in_ready && !start && rst_n;
    if (start) begin sb.delete(); model_clear(); end
    @(posedge clk);
    cyc++;
    if (f) push_model(x, y, p_approx);
    #1;
  endtask

  task automatic pulse_start(input logic [CNT_W-1:0] n);
    start = 1'b1; num_samples = n;
    step();
    start = 1'b0;
  endtask

  // Stand-in for multiplier output: exact, truncated, small-noise or bit-flipped products.
  task automatic gen_sample(output logic signed [W-1:0] xo, output logic signed [W-1:0] yo,
                            output logic signed [2*W-1:0] po);
    longint ex;
    xo = W'($urandom); yo = W'($urandom);
    if ($urandom_range(0, 15) == 0) xo = 16'h8000;
    ex = longint'(xo) * longint'(yo);
    case ($urandom_range(0, 3))
      0:       po = (2*W)'(ex);
      1:       po = (2*W)'(ex) & ~32'h1f;
      2:       po = (2*W)'(ex + longint'($urandom_range(0, 64)) - 32);
      default: po = (2*W)'(ex) ^ (32'h1 << $urandom_range(0, 20));
    endcase
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      n_cmp++;
      if (sample_cnt !== mon_e.cnt || err_cnt !== mon_e.err || sum_abs_err !== mon_e.sabs ||
          max_abs_err !== mon_e.mx || sum_err !== mon_e.sum) begin
        n_bad++;
        $display("FAIL sb_stats cyc=%0d got cnt=%0d err=%0d sabs=%0d max=%0d sum=%0h required cnt=%0d err=%0d sabs=%0d max=%0d sum=%0h",
                 cyc, sample_cnt, err_cnt, sum_abs_err, max_abs_err, sum_err,
                 mon_e.cnt, mon_e.err, mon_e.sabs, mon_e.mx, mon_e.sum);
      end
    end
  end

  task automatic test_reset();
    n_cmp++;
    if ({sample_cnt, err_cnt, sum_abs_err, max_abs_err, sum_err, in_ready, busy, done} !== '0) begin
      n_bad++;
      $display("FAIL reset_state got cnt=%0d ready=%b busy=%b done=%b required all 0",
               sample_cnt, in_ready, busy, done);
    end
    pulse_start(10);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x = W'(i + 2); y = 16'sd3; p_approx = (2*W)'(3 * (i + 2) + 1);
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0; sb.delete(); model_clear();
    #2;
    n_cmp++;
    if ({sample_cnt, err_cnt, sum_abs_err, max_abs_err, sum_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_stats got cnt=%0d sabs=%0d max=%0d required 0", sample_cnt, sum_abs_err, max_abs_err);
    end
    n_cmp++;
    if ({in_ready, busy, done} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_mid_flags got ready=%b busy=%b done=%b required 000", in_ready, busy, done);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({busy, in_ready, done} !== 3'b000 || sample_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_release got busy=%b ready=%b done=%b cnt=%0d required 0 0 0 0",
               busy, in_ready, done, sample_cnt);
    end
  endtask

  task automatic test_single();
    pulse_start(1);
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_run got ready=%b busy=%b required 1 1", in_ready, busy);
    end
    x = 16'sd100; y = -16'sd7; p_approx = -32'sd704; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL single_ready_drop got %b required 0", in_ready);
    end
    step(); step();
    n_cmp++;
    if (done !== 1'b0 || sample_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL single_latency got done=%b cnt=%0d required done=0 cnt=1", done, sample_cnt);
    end
    step();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_done got done=%b busy=%b required 1 0", done, busy);
    end
    n_cmp++;
    if (sample_cnt !== 32'd1 || err_cnt !== 32'd1 || sum_abs_err !== 48'd4 || max_abs_err !== 33'd4 ||
        sum_err !== (SUM_EN ? 48'hFFFF_FFFF_FFFC : 48'd0)) begin
      n_bad++;
      $display("FAIL single_stats got cnt=%0d err=%0d sabs=%0d max=%0d sum=%0h required 1 1 4 4 sum=-4",
               sample_cnt, err_cnt, sum_abs_err, max_abs_err, sum_err);
    end
  endtask

  task automatic test_mixed();
    logic signed [W-1:0]   tx [5] = '{16'sd3, -16'sd20, 16'sd1000, 16'sd77, 16'sd5};
    logic signed [W-1:0]   ty [5] = '{16'sd5, 16'sd10, 16'sd1000, 16'sd2, 16'sd5};
    logic signed [2*W-1:0] tp [5] = '{32'sd15, -32'sd194, 32'sd999998, 32'sd0, 32'sd0};
    pulse_start(3);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x = tx[i]; y = ty[i]; p_approx = tp[i];
      n_cmp++;
      if (in_ready !== (i < 3)) begin
        n_bad++;
        $display("FAIL mixed_ready[%0d] got %b required %b", i, in_ready, (i < 3));
      end
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && done !== 1'b1; i++) step();
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL mixed_done got %b required 1", done);
    end
    n_cmp++;
    if (sample_cnt !== 32'd3 || err_cnt !== 32'd2 || sum_abs_err !== 48'd8 || max_abs_err !== 33'd6 ||
        sum_err !== (SUM_EN ? 48'd4 : 48'd0)) begin
      n_bad++;
      $display("FAIL mixed_stats got cnt=%0d err=%0d sabs=%0d max=%0d sum=%0h required 3 2 8 6 sum=4",
               sample_cnt, err_cnt, sum_abs_err, max_abs_err, sum_err);
    end
  endtask

  task automatic test_backpressure();
    pulse_start(1000);
    for (int i = 0; i < 6000 && done !== 1'b1; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      gen_sample(x, y, p_approx);
      step();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || sample_cnt !== 32'd1000) begin
      n_bad++;
      $display("FAIL bp_done got done=%b cnt=%0d required 1 1000", done, sample_cnt);
    end
    n_cmp++;
    if (err_cnt !== CNT_W'(m_err) || sum_abs_err !== ACC_W'(m_sabs) || max_abs_err !== (2*W+1)'(m_max) ||
        sum_err !== (SUM_EN ? m_sum : '0)) begin
      n_bad++;
      $display("FAIL bp_stats got err=%0d sabs=%0d max=%0d sum=%0h required %0d %0d %0d %0h",
               err_cnt, sum_abs_err, max_abs_err, sum_err, m_err, m_sabs, m_max, m_sum);
    end
  endtask

  task automatic test_restart();
    pulse_start(4);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x = W'(i + 5); y = -16'sd2; p_approx = (2*W)'(-2 * (i + 5) + i);
      step();
    end
    x = 16'sd9; y = 16'sd9; p_approx = '0;
    n_cmp++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_drain got ready=%b busy=%b required 0 1", in_ready, busy);
    end
    start = 1'b1; num_samples = 32'd2;
    step();
    start = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if ({sample_cnt, err_cnt, sum_abs_err, max_abs_err, sum_err} !== '0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_clear got cnt=%0d sabs=%0d ready=%b required 0 0 1", sample_cnt, sum_abs_err, in_ready);
    end
    step(); step(); step();
    n_cmp++;
    if (sample_cnt !== '0 || sum_abs_err !== '0) begin
      n_bad++;
      $display("FAIL restart_flush got cnt=%0d sabs=%0d required 0 0", sample_cnt, sum_abs_err);
    end
    x = 16'sd100; y = 16'sd100; p_approx = '0; in_valid = 1'b1;
    start = 1'b1; num_samples = 32'd2;
    step();
    start = 1'b0;
    x = 16'sd7; y = 16'sd7; p_approx = 32'sd50;
    step();
    x = -16'sd3; y = 16'sd4; p_approx = -32'sd20;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && done !== 1'b1; i++) step();
    n_cmp++;
    if (done !== 1'b1 || sample_cnt !== 32'd2 || err_cnt !== 32'd2 || sum_abs_err !== 48'd9 ||
        max_abs_err !== 33'd8 || sum_err !== (SUM_EN ? 48'hFFFF_FFFF_FFF9 : 48'd0)) begin
      n_bad++;
      $display("FAIL restart_window got done=%b cnt=%0d err=%0d sabs=%0d max=%0d sum=%0h required 1 2 2 9 8 sum=-7",
               done, sample_cnt, err_cnt, sum_abs_err, max_abs_err, sum_err);
    end
  endtask

  task automatic test_zero_window();
    int seen_ready;
    seen_ready = 0;
    in_valid = 1'b1; x = 16'sd11; y = 16'sd11; p_approx = 32'sd1;
    pulse_start(0);
    for (int i = 0; i < 8; i++) begin
      if (in_ready === 1'b1) seen_ready++;
      step();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (seen_ready !== 0 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_window got ready_cycles=%0d done=%b required 0 1", seen_ready, done);
    end
    n_cmp++;
    if ({sample_cnt, err_cnt, sum_abs_err, max_abs_err, sum_err} !== '0) begin
      n_bad++;
      $display("FAIL zero_stats got cnt=%0d sabs=%0d max=%0d required 0", sample_cnt, sum_abs_err, max_abs_err);
    end
  endtask

  task automatic test_saturation();
    s_start = 1'b1; s_num = 32'd70;
    step();
    s_start = 1'b0;
    s_valid = 1'b1; s_x = 16'sd10; s_y = 16'sd10; s_p = 32'sd96;
    for (int i = 0; i < 200 && s_done !== 1'b1; i++) step();
    s_valid = 1'b0;
    n_cmp++;
    if (s_done !== 1'b1 || s_cnt !== 32'd70 || s_err !== 32'd70) begin
      n_bad++;
      $display("FAIL sat_window got done=%b cnt=%0d err=%0d required 1 70 70", s_done, s_cnt, s_err);
    end
    n_cmp++;
    if (s_sabs !== 8'd255 || s_max !== 33'd4 || s_sum !== (SUM_EN ? 8'd232 : 8'd0)) begin
      n_bad++;
      $display("FAIL sat_stats got sabs=%0d max=%0d sum=%0d required 255 4 sum=232",
               s_sabs, s_max, s_sum);
    end
  endtask

  initial begin
    model_clear();
    step(); step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_single();
    test_mixed();
    test_backpressure();
    test_restart();
    test_zero_window();
    test_saturation();
    step(); step();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain got %0d pending required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
